// File: rtl/repeated_sub_divider_if.sv
// Operand/result bus shared between the arithmetic sequencer and the
// repeated-subtraction divider: start/done handshake plus serial operand bus.
interface repeated_sub_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start,
    output data_in,
    input  quotient,
    input  remainder,
    input  busy,
    input  done,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  data_in,
    output quotient,
    output remainder,
    output busy,
    output done,
    output div_by_zero
  );
endinterface

// File: rtl/repeated_sub_divider.sv
// Unsigned divider by repeated subtraction. Dividend and divisor arrive on
// consecutive cycles over data_in after a start; the quotient counts up one
// per subtraction until the running dividend drops below the divisor.
module repeated_sub_divider #(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  repeated_sub_divider_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD_A = 3'd1;
  localparam logic [2:0] LOAD_B = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]       state_r;
  logic [2:0]       state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] q_r;
  logic             dz_r;
  logic             busy_r;
  logic             done_r;
  logic             busy_s;
  logic             done_s;
  logic             b_zero_s;
  logic             a_ge_b_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] q_inc_s;

  // Datapath helpers: full-width unsigned compare, subtractor and counter.
  always_comb begin
    b_zero_s = (b_r == {WIDTH{1'b0}});
    a_ge_b_s = (a_r >= b_r);
    diff_s   = a_r - b_r;
    q_inc_s  = q_r + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = LOAD_A;
        else           state_s = IDLE;
      end
      LOAD_A: state_s = LOAD_B;
      LOAD_B: state_s = RUN;
      RUN: begin
        if (b_zero_s)      state_s = DONE;
        else if (a_ge_b_s) state_s = RUN;
        else               state_s = DONE;
      end
      DONE: begin
        if (bus.start) state_s = LOAD_A;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Status flags decoded from the next state so they leave as flop outputs.
  always_comb begin
    busy_s = (state_s == LOAD_A) || (state_s == LOAD_B) || (state_s == RUN);
    done_s = (state_s == DONE);
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Operand capture and one subtract/increment step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= {WIDTH{1'b0}};
      b_r  <= {WIDTH{1'b0}};
      q_r  <= {WIDTH{1'b0}};
      dz_r <= 1'b0;
    end else begin
      case (state_r)
        LOAD_A: a_r <= bus.data_in;
        LOAD_B: begin
          b_r  <= bus.data_in;
          q_r  <= {WIDTH{1'b0}};
          dz_r <= 1'b0;
        end
        RUN: begin
          if (b_zero_s) begin
            // A is left as the dividend so it reads back as the remainder.
            dz_r <= 1'b1;
            q_r  <= {WIDTH{1'b1}};
          end else if (a_ge_b_s) begin
            a_r <= diff_s;
            q_r <= q_inc_s;
          end else begin
            a_r <= a_r;
          end
        end
        default: begin
          a_r <= a_r;
        end
      endcase
    end
  end

  assign bus.quotient    = q_r;
  assign bus.remainder   = a_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Scoreboard bench for repeated_sub_divider: expectations from a reference
// model are queued when a division is launched and compared when done rises.
module tb_repeated_sub_divider;

  localparam int W       = 16;
  localparam int TIMEOUT = 70000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  repeated_sub_divider_if #(.WIDTH(W)) bus ();

  repeated_sub_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
    int           busy_cycles;
    bit           overlap;
    bit           done_at_e0;
    bit           timeout;
  } obs_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 16'd0) begin
      e.q   = 16'hFFFF;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 3;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dz  = 1'b0;
      e.lat = int'(e.q) + 3;
    end
    return e;
  endfunction

  // Launch one division from IDLE/DONE and watch it until done rises.
  // Edge E0 is the first edge below; n counts edges after E0.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, output obs_t o);
    o.busy_cycles = 0;
    o.overlap     = 1'b0;
    o.done_at_e0  = 1'b0;
    o.timeout     = 1'b1;
    o.lat         = 0;
    o.q           = 16'd0;
    o.r           = 16'd0;
    o.dz          = 1'b0;
    bus.start = 1'b1;
    for (int n = 0; n < TIMEOUT; n++) begin
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1) o.busy_cycles++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) o.overlap = 1'b1;
      if (n == 0) begin
        o.done_at_e0 = (bus.done === 1'b1);
        bus.start    = hold;
        bus.data_in  = a;
      end else if (n == 1) begin
        bus.data_in = b;
      end else if (n == 2) begin
        bus.data_in = 16'($urandom);
      end
      if (n > 0 && bus.done === 1'b1) begin
        o.lat     = n;
        o.q       = bus.quotient;
        o.r       = bus.remainder;
        o.dz      = bus.div_by_zero;
        o.timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.quotient !== 16'd0 || bus.remainder !== 16'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: got q=%h r=%h busy=%b done=%b dz=%b, want all zero",
               bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Basic, small-dividend and zero-dividend divisions, then divide-by-zero
  // followed by a normal division that must clear the flag.
  task automatic test_divisions;
    logic [W-1:0] ta [6] = '{16'd17, 16'd4, 16'd0, 16'd100, 16'd20, 16'd1000};
    logic [W-1:0] tb [6] = '{16'd5,  16'd9, 16'd3, 16'd0,   16'd4,  16'd33};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(model(ta[i], tb[i]));
      do_div(ta[i], tb[i], 1'b0, o);
      e = exp_q.pop_front();
      tests++;
      if (o.timeout) begin
        fails++;
        $display("FAIL div_timeout[%0d]: done not seen within %0d cycles", i, TIMEOUT);
      end
      tests++;
      if (o.q !== e.q || o.r !== e.r || o.dz !== e.dz) begin
        fails++;
        $display("FAIL div_result[%0d] %0d/%0d: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                 i, ta[i], tb[i], o.q, o.r, o.dz, e.q, e.r, e.dz);
      end
      tests++;
      if (o.lat !== e.lat || o.busy_cycles !== e.lat || o.overlap) begin
        fails++;
        $display("FAIL div_timing[%0d]: got latency=%0d busy_cycles=%0d overlap=%b, want %0d %0d 0",
                 i, o.lat, o.busy_cycles, o.overlap, e.lat, e.lat);
      end
      @(posedge clk);
      #1;
      tests++;
      if (bus.done !== 1'b1 || bus.quotient !== e.q || bus.remainder !== e.r) begin
        fails++;
        $display("FAIL done_hold[%0d]: got done=%b q=%0d r=%0d, want 1 %0d %0d",
                 i, bus.done, bus.quotient, bus.remainder, e.q, e.r);
      end
    end
  endtask

  // start held high: DONE lasts one cycle and the next division reloads.
  task automatic test_back_to_back;
    logic [W-1:0] ta [2] = '{16'd17, 16'd30};
    logic [W-1:0] tb [2] = '{16'd5,  16'd7};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model(ta[i], tb[i]));
      do_div(ta[i], tb[i], 1'b1, o);
      e = exp_q.pop_front();
      tests++;
      if (o.timeout || o.q !== e.q || o.r !== e.r || o.dz !== e.dz || o.lat !== e.lat) begin
        fails++;
        $display("FAIL b2b_result[%0d]: got q=%0d r=%0d dz=%b lat=%0d to=%b, want q=%0d r=%0d dz=%b lat=%0d",
                 i, o.q, o.r, o.dz, o.lat, o.timeout, e.q, e.r, e.dz, e.lat);
      end
      tests++;
      if (o.done_at_e0 || o.busy_cycles !== e.lat || o.overlap) begin
        fails++;
        $display("FAIL b2b_pulse[%0d]: got done_after_start=%b busy_cycles=%0d overlap=%b, want 0 %0d 0",
                 i, o.done_at_e0, o.busy_cycles, o.overlap, e.lat);
      end
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reset during a long RUN returns everything to zero/IDLE; a later
  // division is unaffected.
  task automatic test_reset_mid_run;
    obs_t o;
    exp_t e;
    bus.start = 1'b1;
    @(posedge clk); #1;              // E0
    bus.start   = 1'b0;
    bus.data_in = 16'd1000;
    @(posedge clk); #1;              // E1
    bus.data_in = 16'd1;
    @(posedge clk); #1;              // E2
    repeat (9) begin
      @(posedge clk); #1;            // RUN cycles 1..9
    end
    tests++;
    if (bus.busy !== 1'b1 || bus.quotient !== 16'd9) begin
      fails++;
      $display("FAIL mid_run_progress: got busy=%b q=%0d, want 1 9", bus.busy, bus.quotient);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (bus.quotient !== 16'd0 || bus.remainder !== 16'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL mid_run_reset: got q=%h r=%h busy=%b done=%b dz=%b, want all zero",
               bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    exp_q.push_back(model(16'd17, 16'd5));
    do_div(16'd17, 16'd5, 1'b0, o);
    e = exp_q.pop_front();
    tests++;
    if (o.timeout || o.q !== e.q || o.r !== e.r || o.dz !== e.dz || o.lat !== e.lat) begin
      fails++;
      $display("FAIL after_reset_div: got q=%0d r=%0d dz=%b lat=%0d to=%b, want q=%0d r=%0d dz=%b lat=%0d",
               o.q, o.r, o.dz, o.lat, o.timeout, e.q, e.r, e.dz, e.lat);
    end
  endtask

  // Full-scale operands, including the worst-case latency.
  task automatic test_boundary;
    logic [W-1:0] ta [2] = '{16'hFFFF, 16'hFFFF};
    logic [W-1:0] tb [2] = '{16'hFFFF, 16'd1};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(model(ta[i], tb[i]));
      do_div(ta[i], tb[i], 1'b0, o);
      e = exp_q.pop_front();
      tests++;
      if (o.timeout || o.q !== e.q || o.r !== e.r || o.dz !== e.dz) begin
        fails++;
        $display("FAIL boundary_result[%0d]: got q=%0d r=%0d dz=%b to=%b, want q=%0d r=%0d dz=%b",
                 i, o.q, o.r, o.dz, o.timeout, e.q, e.r, e.dz);
      end
      tests++;
      if (o.lat !== e.lat || o.busy_cycles !== e.lat) begin
        fails++;
        $display("FAIL boundary_latency[%0d]: got latency=%0d busy_cycles=%0d, want %0d",
                 i, o.lat, o.busy_cycles, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_divisions();
    test_back_to_back();
    test_reset_mid_run();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
